axi_lite_initiator: RTL and testbench

//  AXI4-Lite initiator (manager) for the 16-bit-data / 18-bit-address bus that our BRAM responders sit on.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_initiator.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_initiator.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: FSM state encoding,
// AXI response codes and the default bus geometry of the BRAM bus.
package axi_lite_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// AXI4-Lite initiator: turns single-beat local commands into one outstanding
// AXI-Lite read or write and returns a registered completion to local logic.
module axi_lite_initiator
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  a_clk,
  input  logic                  a_rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_W-1:0]     aw_addr,
  output logic                  aw_prot,

  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     w_data,
  output logic [DATA_W/8-1:0]   w_strb,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_resp,

  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_W-1:0]     ar_addr,
  output logic                  ar_prot,

  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_W-1:0]     r_data,
  input  logic [1:0]            r_resp
);

  state_t r_state;
  logic   r_awDone;
  logic   r_wDone;

  logic   w_awHs;
  logic   w_wHs;
  logic   w_awDoneNext;
  logic   w_wDoneNext;

  assign cmd_ready    = (r_state == IDLE);
  assign aw_prot      = 1'b0;
  assign ar_prot      = 1'b0;

  // The write address and data channels complete independently, in any order.
  assign w_awHs       = aw_valid & aw_ready;
  assign w_wHs        = w_valid & w_ready;
  assign w_awDoneNext = r_awDone | w_awHs;
  assign w_wDoneNext  = r_wDone | w_wHs;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state   <= IDLE;
      r_awDone  <= 1'b0;
      r_wDone   <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      ar_valid  <= 1'b0;
      b_ready   <= 1'b0;
      r_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            aw_addr   <= cmd_addr;
            ar_addr   <= cmd_addr;
            w_data    <= cmd_wdata;
            w_strb    <= cmd_wstrb;
            rsp_write <= cmd_write;
            if (cmd_write) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              r_awDone <= 1'b0;
              r_wDone  <= 1'b0;
              r_state  <= WR_REQ;
            end else begin
              ar_valid <= 1'b1;
              r_state  <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (w_awHs) begin
            aw_valid <= 1'b0;
            r_awDone <= 1'b1;
          end
          if (w_wHs) begin
            w_valid <= 1'b0;
            r_wDone <= 1'b1;
          end
          if (w_awDoneNext && w_wDoneNext) begin
            b_ready <= 1'b1;
            r_state <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (b_valid && b_ready) begin
            b_ready   <= 1'b0;
            rsp_resp  <= b_resp;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            r_state   <= DONE;
          end
        end

        RD_REQ: begin
          if (ar_valid && ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (r_valid && r_ready) begin
            r_ready   <= 1'b0;
            rsp_rdata <= r_data;
            rsp_resp  <= r_resp;
            rsp_valid <= 1'b1;
            r_state   <= DONE;
          end
        end

        DONE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: a behavioural 4096x16 BRAM responder with
// adjustable per-channel delays, a reference memory model and a rsp scoreboard.
module tb_axi_lite_initiator;
  import axi_lite_pkg::*;

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [17:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready, aw_prot;
  logic [17:0] aw_addr;
  logic        w_valid, w_ready;
  logic [15:0] w_data;
  logic [1:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready, ar_prot;
  logic [17:0] ar_addr;
  logic        r_valid, r_ready;
  logic [15:0] r_data;
  logic [1:0]  r_resp;

  axi_lite_initiator dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    logic        write;
    logic [15:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        expQ[$];
  logic [17:0] addrQ[$];
  logic [15:0] refMem  [4096];
  logic [15:0] bramMem [4096];

  int compared = 0;
  int mismatched = 0;
  int bCount = 0;
  int rspCount = 0;
  int rspHold = 2;
  int awDelay = 0, wDelay = 0, arDelay = 0, bDelay = 0, rDelay = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // The responder flags one address window as faulty: reads return SLVERR/dead, writes DECERR.
  function automatic bit errRegion(input logic [17:0] a);
    return a[17:12] == 6'h2a;
  endfunction

  // Reference model: completions follow command order; memory is word-indexed by addr[11:0].
  task automatic applyStimulus(input logic wr, input logic [17:0] addr,
                               input logic [15:0] data, input logic [1:0] strb);
    exp_t e;
    int   n;
    logic [11:0] idx;
    idx = addr[11:0];
    e.write = wr;
    if (wr) begin
      e.rdata = 16'h0000;
      if (errRegion(addr)) e.resp = RESP_DECERR;
      else begin
        e.resp = RESP_OKAY;
        if (strb[0]) refMem[idx][7:0]  = data[7:0];
        if (strb[1]) refMem[idx][15:8] = data[15:8];
      end
    end else begin
      e.rdata = errRegion(addr) ? 16'hdead : refMem[idx];
      e.resp  = errRegion(addr) ? RESP_SLVERR : RESP_OKAY;
    end
    expQ.push_back(e);
    addrQ.push_back(addr);

    @(posedge a_clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    n = 0;
    forever begin
      @(posedge a_clk);
      if (cmd_ready) break;
      n++;
      if (n > 500) begin
        timeoutFail("cmd_accept");
        break;
      end
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge a_clk);
      if (expQ.size() == 0 && cmd_ready) break;
      n++;
      if (n > 500) begin
        timeoutFail(name);
        break;
      end
    end
  endtask

  // Responder: sample handshakes at the edge, drive the next cycle's signals 1 time unit later.
  logic        awGot, wGot, bPend, rPend, bVal, rVal;
  logic [17:0] sAwAddr;
  logic [15:0] sWData, rDataQ;
  logic [1:0]  sWStrb, bRespQ, rRespQ;
  int          awWait, wWait, arWait, bWait, rWait;

  always @(posedge a_clk) begin
    if (a_rst) begin
      awGot = 0; wGot = 0; bPend = 0; rPend = 0; bVal = 0; rVal = 0;
      awWait = 0; wWait = 0; arWait = 0; bWait = 0; rWait = 0;
    end else begin
      if (b_valid && b_ready) begin
        bPend = 0; bVal = 0; bCount++;
      end else if (bPend) bWait++;
      if (r_valid && r_ready) begin
        rPend = 0; rVal = 0;
      end else if (rPend) rWait++;

      if (aw_valid && aw_ready) begin
        awGot = 1; sAwAddr = aw_addr; awWait = 0;
        if (addrQ.size() == 0) timeoutFail("aw_unexpected");
        else checkOutput("aw_addr", aw_addr, addrQ.pop_front());
      end else if (aw_valid) awWait++;

      if (w_valid && w_ready) begin
        wGot = 1; sWData = w_data; sWStrb = w_strb; wWait = 0;
      end else if (w_valid) wWait++;

      if (ar_valid && ar_ready) begin
        if (addrQ.size() == 0) timeoutFail("ar_unexpected");
        else checkOutput("ar_addr", ar_addr, addrQ.pop_front());
        rDataQ = errRegion(ar_addr) ? 16'hdead : bramMem[ar_addr[11:0]];
        rRespQ = errRegion(ar_addr) ? RESP_SLVERR : RESP_OKAY;
        rPend = 1; rWait = 0; arWait = 0;
      end else if (ar_valid) arWait++;

      if (awGot && wGot) begin
        if (errRegion(sAwAddr)) bRespQ = RESP_DECERR;
        else begin
          bRespQ = RESP_OKAY;
          if (sWStrb[0]) bramMem[sAwAddr[11:0]][7:0]  = sWData[7:0];
          if (sWStrb[1]) bramMem[sAwAddr[11:0]][15:8] = sWData[15:8];
        end
        bPend = 1; bWait = 0; awGot = 0; wGot = 0;
      end
    end
    #1;
    aw_ready = aw_valid && !awGot && (awWait >= awDelay);
    w_ready  = w_valid && !wGot && (wWait >= wDelay);
    ar_ready = ar_valid && (arWait >= arDelay);
    bVal     = bVal || (bPend && bWait >= bDelay);
    rVal     = rVal || (rPend && rWait >= rDelay);
    b_valid  = bVal;
    b_resp   = bVal ? bRespQ : 2'b00;
    r_valid  = rVal;
    r_data   = rVal ? rDataQ : 16'h0000;
    r_resp   = rVal ? rRespQ : 2'b00;
  end

  always @(posedge a_clk) begin
    #1;
    case (rspHold)
      1:       rsp_ready = 1'b0;
      2:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Scoreboard monitor: every completion handshake pops one expectation.
  always @(negedge a_clk) begin
    exp_t e;
    if (!a_rst && rsp_valid && rsp_ready) begin
      rspCount++;
      if (expQ.size() == 0) timeoutFail("rsp_unexpected");
      else begin
        e = expQ.pop_front();
        checkOutput("rsp", {rsp_write, rsp_rdata, rsp_resp}, {e.write, e.rdata, e.resp});
      end
    end
  end

  // A stalled valid must stay up with an unchanged payload.
  logic        pAw = 0, pW = 0, pAr = 0;
  logic [17:0] pAwA, pArA;
  logic [15:0] pWd;
  logic [1:0]  pWs;
  always @(negedge a_clk) begin
    if (a_rst) begin
      pAw = 0; pW = 0; pAr = 0;
    end else begin
      if (pAw) checkOutput("aw_hold", {aw_valid, aw_addr}, {1'b1, pAwA});
      if (pW)  checkOutput("w_hold", {w_valid, w_data, w_strb}, {1'b1, pWd, pWs});
      if (pAr) checkOutput("ar_hold", {ar_valid, ar_addr}, {1'b1, pArA});
      pAw = aw_valid && !aw_ready; pAwA = aw_addr;
      pW  = w_valid && !w_ready;   pWd = w_data; pWs = w_strb;
      pAr = ar_valid && !ar_ready; pArA = ar_addr;
    end
  end

  initial begin
    int b0, r0, n;
    logic [15:0] held;
    logic [5:0]  hiSel [4];
    hiSel[0] = 6'h00; hiSel[1] = 6'h01; hiSel[2] = 6'h2a; hiSel[3] = 6'h3f;

    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0;
    for (int i = 0; i < 4096; i++) begin
      refMem[i] = 16'h0000;
      bramMem[i] = 16'h0000;
    end

    a_rst = 1'b1;
    repeat (3) @(posedge a_clk);
    @(negedge a_clk);
    checkOutput("reset_ctrl",
      {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_write, rsp_resp, aw_prot, ar_prot, w_strb},
      13'h0);
    checkOutput("reset_addr", {rsp_rdata, aw_addr, ar_addr}, 52'h0);
    checkOutput("reset_wdata", w_data, 16'h0);
    @(posedge a_clk); #1;
    a_rst = 1'b0;
    @(negedge a_clk);
    checkOutput("cmd_ready_after_reset", cmd_ready, 1'b1);

    $display("[TB] write then read back 0x00648");
    applyStimulus(1'b1, 18'h00648, 16'h55aa, 2'b11);
    applyStimulus(1'b0, 18'h00648, 16'h0000, 2'b00);
    waitDrain("drain_t1");

    $display("[TB] w beat three cycles before aw beat");
    awDelay = 3; wDelay = 0;
    b0 = bCount; r0 = rspCount;
    applyStimulus(1'b1, 18'h00100, 16'h1234, 2'b01);
    @(negedge a_clk);
    @(negedge a_clk);
    checkOutput("w_drop_aw_held", {w_valid, aw_valid}, 2'b01);
    waitDrain("drain_t2");
    checkOutput("one_b_beat", bCount - b0, 1);
    checkOutput("one_rsp", rspCount - r0, 1);
    awDelay = 0;
    applyStimulus(1'b0, 18'h00100, 16'h0000, 2'b00);
    waitDrain("drain_t2b");

    $display("[TB] completion stalled by rsp_ready");
    rspHold = 1;
    applyStimulus(1'b0, 18'h00648, 16'h0000, 2'b00);
    n = 0;
    forever begin
      @(negedge a_clk);
      if (rsp_valid) break;
      n++;
      if (n > 100) begin timeoutFail("rsp_valid_t3"); break; end
    end
    held = rsp_rdata;
    checkOutput("stall_rdata", held, 16'h55aa);
    repeat (5) begin
      @(negedge a_clk);
      checkOutput("rsp_stall", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, held, 1'b0});
    end
    rspHold = 2;
    n = 0;
    forever begin
      @(negedge a_clk);
      if (rsp_valid && rsp_ready) break;
      n++;
      if (n > 20) begin timeoutFail("rsp_handshake_t3"); break; end
    end
    @(negedge a_clk);
    checkOutput("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);

    $display("[TB] error responses");
    applyStimulus(1'b0, 18'h2a000, 16'h0000, 2'b00);
    applyStimulus(1'b1, 18'h2a010, 16'hffff, 2'b11);
    waitDrain("drain_t4");

    $display("[TB] reset during read response");
    rDelay = 20;
    applyStimulus(1'b0, 18'h00648, 16'h0000, 2'b00);
    n = 0;
    forever begin
      @(negedge a_clk);
      if (r_ready) break;
      n++;
      if (n > 50) begin timeoutFail("r_ready_t5"); break; end
    end
    @(posedge a_clk); #1;
    a_rst = 1'b1;
    @(posedge a_clk); #1;
    a_rst = 1'b0;
    if (expQ.size() > 0) expQ.delete(expQ.size() - 1);
    @(negedge a_clk);
    checkOutput("abandon_read", {ar_valid, r_ready, rsp_valid, cmd_ready}, 4'b0001);
    rDelay = 0;
    repeat (3) @(negedge a_clk);

    $display("[TB] back-to-back reads at the address extremes");
    applyStimulus(1'b1, 18'h3ffff, 16'hbeef, 2'b11);
    applyStimulus(1'b1, 18'h00000, 16'h0bad, 2'b11);
    applyStimulus(1'b0, 18'h3ffff, 16'h0000, 2'b00);
    applyStimulus(1'b0, 18'h00000, 16'h0000, 2'b00);
    waitDrain("drain_t6");

    $display("[TB] randomized traffic");
    rspHold = 0;
    repeat (60) begin
      awDelay = $urandom_range(0, 3);
      wDelay  = $urandom_range(0, 3);
      arDelay = $urandom_range(0, 3);
      bDelay  = $urandom_range(0, 3);
      rDelay  = $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)),
                    {hiSel[$urandom_range(0, 3)], 12'($urandom_range(0, 15))},
                    16'($urandom), 2'($urandom_range(0, 3)));
    end
    waitDrain("drain_random");
    checkOutput("addr_queue_empty", addrQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
